ecc_pt_loader: RTL
==================

// Module: ecc_pt_loader
// PURPOSE
//  Host-side point loader upstream of the P2 register. Collects one affine point (X then Y)
//  as a stream of DW-bit words from the SPI/host write path. Range-checks both coordinates
//  against the field prime, then presents them on x/y with a valid/ready handshake.
//  The core controller consumes a presented point by pulsing p2_en with p2_op = P2_SET_T.
// PARAMETERS
//  DW       32                  host word width; CW % DW == 0 required
//  CW       256                 coordinate width
//  FIELD_P  256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff  field prime
//  NW       CW/DW (derived)     words per coordinate (8 at default)
// PORTS
//  clk       in   1    clock
//  rst_n     in   1    reset, asynchronous, active-low
//  abort     in   1    synchronous flush: discard partial/held point, clear error
//  wr_valid  in   1    host word valid
//  wr_ready  out  1    loader accepts word (transfer = wr_valid & wr_ready)
//  wr_data   in   DW   host word; most-significant word of each coordinate first
//  pt_valid  out  1    x/y hold a complete, in-range point
//  pt_take   in   1    consumer takes point (transfer = pt_valid & pt_take)
//  x         out  CW   X coordinate to P2 register
//  y         out  CW   Y coordinate to P2 register
//  err       out  1    sticky: last point had X >= FIELD_P or Y >= FIELD_P
//  busy      out  1    high while a point is partially loaded or held
// BEHAVIOUR
//  Reset: state LOAD_X, word count 0, x = y = 0, wr_ready=1, pt_valid=0, err=0, busy=0.
//  FSM: LOAD_X -> LOAD_Y -> CHECK -> HOLD -> LOAD_X; CHECK -> ERR on range failure.
//  LOAD_X/LOAD_Y: wr_ready=1. Each transfer shifts in: coord <= {coord[CW-DW-1:0], wr_data}.
//   Count wraps after NW words. LOAD_X -> LOAD_Y after word NW-1; LOAD_Y -> CHECK after word NW-1.
//   Idle cycles (wr_valid=0) between words are allowed; no timeout.
//  CHECK: exactly 1 cycle, wr_ready=0. Compare x < FIELD_P and y < FIELD_P (unsigned, full CW).
//   Both pass -> HOLD. Otherwise -> ERR, err<=1.
//  HOLD: pt_valid=1, wr_ready=0; x/y stable. On pt_take -> LOAD_X next cycle, pt_valid<=0.
//   x/y keep their value after the take until overwritten by the next load.
//  ERR: wr_ready=0, pt_valid=0; leaves only on abort (-> LOAD_X, err<=0).
//  Latency: last Y word accepted at cycle t -> pt_valid=1 at cycle t+2.
//  busy = (state != LOAD_X) | (count != 0), except in ERR where busy=0.
//  abort (any state, incl. same cycle as wr transfer or pt_take): abort wins. Next state
//   LOAD_X, count 0, pt_valid 0, err 0. The coincident word/take is ignored. x/y are not cleared.
//  Reset mid-load: all state lost immediately; no partial point is ever presented.
//  A value equal to FIELD_P is out of range. 0 is in range; no on-curve check is done here.
// STRUCTURE
//  Shared package/include ecc_defs: P2_SET_N/M/T op codes, FIELD_P, CW; used by this block,
//   the P2 register, and the core controller.
//  Loader-local: state encodings (LOAD_X, LOAD_Y, CHECK, HOLD, ERR).
//  One sub-module: ecc_lt_cmp (combinational CW-bit unsigned a < b). Instantiate twice (x, y).
//  Registered outputs only; no combinational path from wr_* to pt_* or from pt_take to wr_ready.
// TESTING
//  Load X=1, Y=2 (16 words, back-to-back) -> pt_valid 2 cycles after last word; x=1, y=2; err=0.
//  Present X=FIELD_P, Y=5 -> err=1 and pt_valid never rises. Words ignored (wr_ready=0)
//   until abort; then err=0 and a good point loads normally.
//  X=FIELD_P-1, Y=FIELD_P-1 -> accepted. Hold pt_take low 10 cycles -> pt_valid and x/y stable,
//   wr_ready=0. Pulse pt_take -> pt_valid=0 and wr_ready=1 next cycle.
//  Random wr_valid gaps (50% duty), X=0xA5..A5, Y=0x5A..5A -> same result as back-to-back;
//   MS word first ordering checked.
//  Abort after 5 X words, asserted with wr_valid=1 -> that word dropped, count 0. A following full
//   load yields exactly the new point.
//  Assert rst_n low during LOAD_Y and during HOLD -> all outputs at reset values asynchronously;
//   point not presented.

Source files
------------

// File: rtl/ecc_defs.sv
// Shared ECC definitions used by the point loader, the P2 register and the
// core controller: coordinate width, field prime and P2 register op codes.
package ecc_defs;

  localparam int CW = 256;

  localparam logic [CW-1:0] FIELD_P =
    256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

  // P2 register operations issued by the core controller on p2_en.
  // P2_SET_T latches the point currently presented by the loader.
  typedef enum logic [1:0] {
    P2_SET_N = 2'd0,
    P2_SET_M = 2'd1,
    P2_SET_T = 2'd2
  } p2_op_t;

endpackage

// File: rtl/ecc_pt_loader_pkg.sv
// Loader-local definitions: FSM state encoding and a counter-width helper.
package ecc_pt_loader_pkg;

  typedef enum logic [2:0] {
    LOAD_X = 3'd0,
    LOAD_Y = 3'd1,
    CHECK  = 3'd2,
    HOLD   = 3'd3,
    ERR    = 3'd4
  } ld_state_t;

  // Word counter width; a single-word coordinate still gets a 1-bit counter.
  function automatic int cnt_width(input int nw);
    return (nw > 1) ? $clog2(nw) : 1;
  endfunction

endpackage

// File: rtl/ecc_pt_loader_lt_cmp.sv
// ecc_lt_cmp: combinational unsigned a < b over the full coordinate width.
module ecc_lt_cmp #(
  parameter int W = 256
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  assign lt = (a < b);

endmodule

// File: rtl/ecc_pt_loader.sv
// ecc_pt_loader: collects one affine point (X then Y, MS word first) from the
// host write stream, range-checks both coordinates against the field prime and
// presents the point to the P2 register.
//
// Handshakes (both strict valid/ready):
//   host side:     a word transfers on a rising clk edge where wr_valid & wr_ready;
//                  wr_valid may drop between words for any number of cycles.
//   consumer side: a point transfers on a rising clk edge where pt_valid & pt_take;
//                  pt_valid stays high and x/y stay stable until that edge.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module ecc_pt_loader
  import ecc_pt_loader_pkg::*;
#(
  parameter int              DW      = 32,
  parameter int              CW      = ecc_defs::CW,
  parameter logic [CW-1:0]   FIELD_P = ecc_defs::FIELD_P
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          abort,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          pt_valid,
  input  logic          pt_take,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          err,
  output logic          busy
);

  localparam int NW    = CW / DW;
  localparam int CNT_W = cnt_width(NW);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ld_state_t        state;
  ld_state_t        state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             shift_x;
  logic             shift_y;
  logic             x_in_range;
  logic             y_in_range;

  ecc_lt_cmp #(.W(CW)) u_cmp_x (
    .a  (x),
    .b  (FIELD_P),
    .lt (x_in_range)
  );

  ecc_lt_cmp #(.W(CW)) u_cmp_y (
    .a  (y),
    .b  (FIELD_P),
    .lt (y_in_range)
  );

  // Next-state, word counter and shift enables; abort overrides everything,
  // including a coincident word transfer or point take.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    shift_x   = 1'b0;
    shift_y   = 1'b0;
    if (abort) begin
      state_nxt = LOAD_X;
      count_nxt = '0;
    end else begin
      case (state)
        LOAD_X: begin
          if (wr_valid) begin
            shift_x = 1'b1;
            if (count == CNT_LAST) begin
              count_nxt = '0;
              state_nxt = LOAD_Y;
            end else begin
              count_nxt = count + CNT_ONE;
            end
          end
        end
        LOAD_Y: begin
          if (wr_valid) begin
            shift_y = 1'b1;
            if (count == CNT_LAST) begin
              count_nxt = '0;
              state_nxt = CHECK;
            end else begin
              count_nxt = count + CNT_ONE;
            end
          end
        end
        CHECK: begin
          state_nxt = (x_in_range && y_in_range) ? HOLD : ERR;
        end
        HOLD: begin
          if (pt_take) begin
            state_nxt = LOAD_X;
          end
        end
        ERR: begin
          state_nxt = ERR;
        end
        default: begin
          state_nxt = LOAD_X;
          count_nxt = '0;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_X;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Coordinate shift registers; they are never cleared by abort or a take,
  // only overwritten by the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      if (shift_x) begin
        x <= (x << DW) | CW'(wr_data);
      end
      if (shift_y) begin
        y <= (y << DW) | CW'(wr_data);
      end
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready <= 1'b1;
      pt_valid <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_ready <= (state_nxt == LOAD_X) || (state_nxt == LOAD_Y);
      pt_valid <= (state_nxt == HOLD);
      err      <= (state_nxt == ERR);
      busy     <= (state_nxt != ERR) &&
                  ((state_nxt != LOAD_X) || (count_nxt != '0));
    end
  end

endmodule
